// File: rtl/spi_image_pkg.sv
// Shared constants and FSM state type for the SPI process-image slave.
package spi_image_pkg;

  localparam int IMG_W_DEF = 512;
  localparam int IMG_BYTES = IMG_W_DEF / 8;
  localparam int CNT_W     = $clog2(IMG_W_DEF + 2);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_e;

  // Counter must hold 0..img_w+1 so an overrun is distinguishable from a full frame.
  function automatic int cnt_width(input int img_w);
    return $clog2(img_w + 2);
  endfunction

endpackage

// File: rtl/spi_image_slave_pin_sync.sv
// Synchroniser flop chain for one SPI pin plus rise/fall detection on the synced level.
module spi_pin_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;
  assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_image_slave.sv
// SPI mode-0 slave exchanging one IMG_W-bit image per chip-select frame, oversampled on CLK.
// Optional build macro SPI_XOR_CHECK_EN: accept a full frame only if the XOR of all received bytes is zero.
module spi_image_slave
  import spi_image_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             SPI_SCK,
  input  logic             SPI_CS_N,
  input  logic             SPI_MOSI,
  output logic             SPI_MISO,
  output logic             SPI_MISO_OE,
  input  logic [IMG_W-1:0] TX_DATA,
  output logic [IMG_W-1:0] RX_DATA,
  output logic             RX_VALID,
  output logic             RX_ERR,
  output logic             FRAME_ACTIVE
);

  localparam int             CW       = cnt_width(IMG_W);
  localparam logic [CW-1:0]  CNT_FULL = CW'(IMG_W);
  localparam logic [CW-1:0]  CNT_OVR  = CW'(IMG_W + 1);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic mosi_s, mosi_rise, mosi_fall;

  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk(CLK), .rst_n(RST_N), .d(SPI_SCK), .q(sck_s), .rise(sck_rise), .fall(sck_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(CLK), .rst_n(RST_N), .d(SPI_CS_N), .q(cs_s), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(CLK), .rst_n(RST_N), .d(SPI_MOSI), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
  );

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IMG_W-1:0] tx_q, tx_d;
  logic [IMG_W-1:0] rx_shift_q, rx_shift_d;
  logic [IMG_W-1:0] rx_data_q, rx_data_d;
  logic             miso_q, miso_d;
  logic             active_q, active_d;
  logic             rx_valid_q, rx_valid_d;
  logic             rx_err_q, rx_err_d;
  logic             chk_ok;

`ifdef SPI_XOR_CHECK_EN
  logic [7:0] xor_q, xor_d;

  // Running XOR: bit n of every byte lands on xor bit n, so the result is the XOR of all bytes.
  always_comb begin
    xor_d = xor_q;
    if (state_q == IDLE && cs_fall) begin
      xor_d = 8'h00;
    end else if (state_q == SHIFT && !cs_rise && sck_rise && cnt_q < CNT_FULL) begin
      xor_d[cnt_q[2:0]] = xor_q[cnt_q[2:0]] ^ mosi_s;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) xor_q <= 8'h00;
    else        xor_q <= xor_d;
  end

  assign chk_ok = (xor_q == 8'h00);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    miso_d     = miso_q;
    active_d   = active_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          tx_d     = TX_DATA;
          cnt_d    = '0;
          active_d = 1'b1;
          miso_d   = TX_DATA[0];
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // A CS_N rise takes priority over any SCK edge seen in the same cycle.
        if (cs_rise) begin
          state_d = DONE;
        end else if (sck_rise) begin
          if (cnt_q < CNT_FULL) rx_shift_d = {mosi_s, rx_shift_q[IMG_W-1:1]};
          if (cnt_q != CNT_OVR) cnt_d = cnt_q + CW'(1);
        end else if (sck_fall) begin
          // Zeros shift in from the top, so MISO reads 0 once the image is exhausted.
          tx_d   = {1'b0, tx_q[IMG_W-1:1]};
          miso_d = tx_q[1];
        end
      end
      DONE: begin
        if (cnt_q == CNT_FULL && chk_ok) begin
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
        end else begin
          rx_err_d = 1'b1;
        end
        active_d = 1'b0;
        miso_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rx_data_q  <= '0;
      miso_q     <= 1'b0;
      active_q   <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_data_q  <= rx_data_d;
      miso_q     <= miso_d;
      active_q   <= active_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    tx_q       <= tx_d;
    rx_shift_q <= rx_shift_d;
  end

  assign SPI_MISO     = miso_q;
  assign SPI_MISO_OE  = active_q;
  assign FRAME_ACTIVE = active_q;
  assign RX_DATA      = rx_data_q;
  assign RX_VALID     = rx_valid_q;
  assign RX_ERR       = rx_err_q;

  logic unused_sync;
  assign unused_sync = ^{sck_s, cs_s, mosi_rise, mosi_fall, tx_q[0]};

endmodule

// File: tb/tb_spi_image_slave.sv
// Scoreboard bench for spi_image_slave: drives mode-0 SPI frames and checks MISO, RX pulses and RX_DATA.
module tb_spi_image_slave;

  localparam int W    = 512;
  localparam int HALF = 5;
`ifdef SPI_XOR_CHECK_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  logic         CLK, RST_N, SPI_SCK, SPI_CS_N, SPI_MOSI;
  logic         SPI_MISO, SPI_MISO_OE, RX_VALID, RX_ERR, FRAME_ACTIVE;
  logic [W-1:0] TX_DATA, RX_DATA;

  spi_image_slave #(.IMG_W(W), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .SPI_SCK(SPI_SCK), .SPI_CS_N(SPI_CS_N), .SPI_MOSI(SPI_MOSI),
    .SPI_MISO(SPI_MISO), .SPI_MISO_OE(SPI_MISO_OE), .TX_DATA(TX_DATA), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .RX_ERR(RX_ERR), .FRAME_ACTIVE(FRAME_ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic         is_err;
    logic [W-1:0] data;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] last_rx;
  int           n_vec, n_err;

  function automatic logic [W-1:0] rand_img();
    logic [W-1:0] v;
    for (int w = 0; w < W / 32; w++) v[32*w +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [W-1:0] ramp_img();
    logic [W-1:0] v;
    for (int k = 0; k < W / 8; k++) v[8*k +: 8] = 8'(k);
    return v;
  endfunction

  task automatic push_exp(input logic is_err, input logic [W-1:0] img);
    exp_t e;
    if (!is_err) last_rx = img;
    e.is_err = is_err;
    e.data   = is_err ? last_rx : img;
    sb.push_back(e);
  endtask

  // Mode 0: MOSI changes after SCK falls; MISO is captured just before SCK rises.
  task automatic spi_frame(input logic [W-1:0] mosi_img, input int nbits, input bit abort,
                           output logic [519:0] cap);
    cap = '0;
    @(negedge CLK);
    SPI_CS_N = 1'b0;
    SPI_MOSI = mosi_img[0];
    repeat (8) @(negedge CLK);
    n_vec++;
    if ({FRAME_ACTIVE, SPI_MISO_OE} !== 2'b11) begin
      n_err++;
      $display("FAIL frame_active_oe got=%b want=11", {FRAME_ACTIVE, SPI_MISO_OE});
    end
    for (int i = 0; i < nbits; i++) begin
      cap[i]  = SPI_MISO;
      SPI_SCK = 1'b1;
      repeat (HALF) @(negedge CLK);
      SPI_SCK = 1'b0;
      if (i + 1 < W) SPI_MOSI = mosi_img[i+1];
      else           SPI_MOSI = 1'b0;
      repeat (HALF) @(negedge CLK);
    end
    if (abort) begin
      RST_N = 1'b0;
      repeat (2) @(negedge CLK);
      SPI_CS_N = 1'b1;
      SPI_MOSI = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
    end else begin
      SPI_CS_N = 1'b1;
    end
  endtask

  task automatic check_pulses(input string name);
    int   seen  = 0;
    int   exp_n = sb.size();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      @(negedge CLK);
      if (RX_VALID || RX_ERR) begin
        seen++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL %s extra pulse valid=%b err=%b", name, RX_VALID, RX_ERR);
        end else begin
          e = sb.pop_front();
          if ({RX_VALID, RX_ERR} !== (e.is_err ? 2'b01 : 2'b10) || RX_DATA !== e.data) begin
            n_err++;
            $display("FAIL %s pulse got v/e=%b%b data=%h want v/e=%b%b data=%h", name, RX_VALID,
                     RX_ERR, RX_DATA, !e.is_err, e.is_err, e.data);
          end
        end
      end
    end
    n_vec++;
    if (seen != exp_n) begin
      n_err++;
      $display("FAIL %s pulse_count got=%0d want=%0d", name, seen, exp_n);
    end
    sb.delete();
    n_vec++;
    if ({FRAME_ACTIVE, SPI_MISO_OE, SPI_MISO} !== 3'b000) begin
      n_err++;
      $display("FAIL %s idle_pins got=%b want=000", name, {FRAME_ACTIVE, SPI_MISO_OE, SPI_MISO});
    end
  endtask

  task automatic test_reset();
    TX_DATA = rand_img();
    repeat (3) @(negedge CLK);
    n_vec++; if (SPI_MISO !== 1'b0)     begin n_err++; $display("FAIL rst_miso got=%b want=0", SPI_MISO); end
    n_vec++; if (SPI_MISO_OE !== 1'b0)  begin n_err++; $display("FAIL rst_oe got=%b want=0", SPI_MISO_OE); end
    n_vec++; if (RX_DATA !== '0)        begin n_err++; $display("FAIL rst_rx_data got=%h want=0", RX_DATA); end
    n_vec++; if (RX_VALID !== 1'b0)     begin n_err++; $display("FAIL rst_rx_valid got=%b want=0", RX_VALID); end
    n_vec++; if (RX_ERR !== 1'b0)       begin n_err++; $display("FAIL rst_rx_err got=%b want=0", RX_ERR); end
    n_vec++; if (FRAME_ACTIVE !== 1'b0) begin n_err++; $display("FAIL rst_active got=%b want=0", FRAME_ACTIVE); end
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    n_vec++;
    if ({FRAME_ACTIVE, RX_VALID, RX_ERR} !== 3'b000) begin
      n_err++;
      $display("FAIL post_rst_idle got=%b want=000", {FRAME_ACTIVE, RX_VALID, RX_ERR});
    end
  endtask

  task automatic test_single_bit();
    logic [519:0] cap;
    logic [W-1:0] tx;
    tx      = '0;
    tx[0]   = 1'b1;
    TX_DATA = tx;
    push_exp(1'b0, '0);
    spi_frame('0, W, 1'b0, cap);
    n_vec++;
    if (cap[W-1:0] !== tx) begin
      n_err++;
      $display("FAIL single_bit_miso got=%h want=%h", cap[W-1:0], tx);
    end
    check_pulses("single_bit");
  endtask

  task automatic test_ramp();
    logic [519:0] cap;
    logic [W-1:0] tx;
    tx      = rand_img();
    TX_DATA = tx;
    push_exp(1'b0, ramp_img());
    spi_frame(ramp_img(), W, 1'b0, cap);
    TX_DATA = ~tx;
    n_vec++;
    if (cap[W-1:0] !== tx) begin
      n_err++;
      $display("FAIL ramp_miso got=%h want=%h", cap[W-1:0], tx);
    end
    check_pulses("ramp");
  endtask

  task automatic test_short();
    logic [519:0] cap;
    logic [W-1:0] tx;
    tx      = rand_img();
    TX_DATA = tx;
    push_exp(1'b1, '0);
    spi_frame(rand_img(), 300, 1'b0, cap);
    n_vec++;
    if (cap[299:0] !== tx[299:0]) begin
      n_err++;
      $display("FAIL short_miso got=%h want=%h", cap[299:0], tx[299:0]);
    end
    check_pulses("short");
  endtask

  task automatic test_overrun();
    logic [519:0] cap;
    logic [W-1:0] tx;
    tx      = rand_img();
    TX_DATA = tx;
    push_exp(1'b1, '0);
    spi_frame(rand_img(), W + 1, 1'b0, cap);
    n_vec++;
    if (cap[W-1:0] !== tx) begin
      n_err++;
      $display("FAIL overrun_miso got=%h want=%h", cap[W-1:0], tx);
    end
    n_vec++;
    if (cap[W] !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_tail_miso got=%b want=0", cap[W]);
    end
    check_pulses("overrun");
  endtask

  task automatic test_xor();
    logic [519:0] cap;
    logic [W-1:0] img;
    logic [7:0]   x;
    img = ramp_img();
    x   = 8'h00;
    for (int k = 0; k < W / 8 - 1; k++) x = x ^ img[8*k +: 8];
    img[W-8 +: 8] = x;
    TX_DATA = rand_img();
    push_exp(1'b0, img);
    spi_frame(img, W, 1'b0, cap);
    check_pulses("xor_good");
    img[100] = ~img[100];
    push_exp(XOR_EN, img);
    spi_frame(img, W, 1'b0, cap);
    check_pulses("xor_flip");
  endtask

  task automatic test_reset_abort();
    logic [519:0] cap;
    logic [W-1:0] img;
    TX_DATA = rand_img();
    spi_frame(rand_img(), 200, 1'b1, cap);
    last_rx = '0;
    check_pulses("abort");
    n_vec++;
    if (RX_DATA !== '0) begin
      n_err++;
      $display("FAIL abort_rx_data got=%h want=0", RX_DATA);
    end
    img = rand_img();
    push_exp(1'b0, img);
    spi_frame(img, W, 1'b0, cap);
    check_pulses("after_abort");
  endtask

  task automatic test_back_to_back();
    logic [519:0] cap;
    logic [W-1:0] img, tx;
    for (int f = 0; f < 2; f++) begin
      img     = rand_img();
      tx      = rand_img();
      TX_DATA = tx;
      push_exp(1'b0, img);
      spi_frame(img, W, 1'b0, cap);
      n_vec++;
      if (cap[W-1:0] !== tx) begin
        n_err++;
        $display("FAIL b2b_miso frame=%0d got=%h want=%h", f, cap[W-1:0], tx);
      end
      check_pulses("b2b");
    end
    @(negedge CLK);
    SPI_CS_N = 1'b0;
    @(negedge CLK);
    SPI_CS_N = 1'b1;
    push_exp(1'b1, '0);
    check_pulses("cs_glitch");
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    last_rx  = '0;
    RST_N    = 1'b0;
    SPI_SCK  = 1'b0;
    SPI_CS_N = 1'b1;
    SPI_MOSI = 1'b0;
    TX_DATA  = '0;
    test_reset();
    test_single_bit();
    test_ramp();
    test_short();
    test_overrun();
    test_xor();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
